// File: rtl/regfile_wport_arbiter_pkg.sv
// rtl/regfile_wport_arbiter_pkg.sv - shared constants for the register-file write-port arbiter
package regfile_wport_arbiter_pkg;

    localparam int REQ_WB   = 0;
    localparam int NREQ_DEF = 3;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

endpackage

// File: rtl/regfile_wport_arbiter_rr.sv
// rtl/regfile_wport_arbiter_rr.sv - combinational round-robin picker, first valid at or after ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - shares the register-file write port among NREQ writers
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic              stall_req,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     wdata
);

    localparam int NLOW = NREQ - 1;
    localparam int IW   = $clog2(NREQ);
    localparam int PW   = (NLOW > 1) ? $clog2(NLOW) : 1;
    localparam int CW   = $clog2(STARVE_LIM + 1);

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   next_ptr;
    logic [PW-1:0]   ptr_low;
    logic [CW-1:0]   starve_cnt;
    logic            force_grant;
    logic            force_d;
    logic            starve_inc;
    logic [NLOW-1:0] low_valid;
    logic [NLOW-1:0] low_grant;
    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic            low_granted;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    assign low_valid = req_valid[NREQ-1:1];
    // rr_ptr counts over 1..NREQ-1; the picker indexes the low requesters from 0
    assign ptr_low   = PW'(rr_ptr - IW'(1));

    rr_arbiter #(.N(NLOW), .PW(PW)) u_rr (
        .req   (low_valid),
        .ptr   (ptr_low),
        .grant (low_grant)
    );

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (force_grant) begin
                grant[NREQ-1:1] = low_grant;
            end else if (req_valid[REQ_WB]) begin
                grant[REQ_WB] = 1'b1;
            end else begin
                grant[NREQ-1:1] = low_grant;
            end
        end
    end

    assign req_ready   = grant;
    assign stall_req   = force_grant & ~rst;
    assign any_grant   = |grant;
    assign low_granted = |grant[NREQ-1:1];

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        next_ptr = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                if (i != REQ_WB) begin
                    next_ptr = (i == NREQ - 1) ? IW'(1) : IW'(i + 1);
                end
            end
        end
    end

    assign starve_inc = (|low_valid) && !low_granted;
    // force also drops when the low requesters withdraw, since starve_inc goes low
    assign force_d    = starve_inc && (starve_cnt == CW'(STARVE_LIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            rr_ptr      <= IW'(1);
            starve_cnt  <= '0;
            force_grant <= 1'b0;
        end else begin
            we <= any_grant && (sel_addr != '0);
            if (any_grant && (sel_addr != '0)) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
            rr_ptr <= next_ptr;
            if (low_granted) begin
                starve_cnt <= '0;
            end else if (starve_inc && (starve_cnt != CW'(STARVE_LIM))) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
            force_grant <= force_d;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - directed plus randomized check against a behavioural model
module tb_regfile_wport_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LIM  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '1;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_data  = '0;
    logic [NREQ-1:0]    req_ready;
    logic              stall_req;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;

    regfile_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .stall_req (stall_req),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state: what the port should show, plus arbitration history
    int            m_ptr   = 1;
    int            m_cnt   = 0;
    int            m_grant = -1;
    bit            m_force = 1'b0;
    bit            m_we    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;

    logic [NREQ-1:0] obs_ready;
    logic            obs_stall;
    logic            obs_we;
    logic [AW-1:0]   obs_waddr;
    logic [DW-1:0]   obs_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int low;
        low = -1;
        if (rst) return -1;
        for (int k = 0; k < NREQ - 1; k++) begin
            int i;
            i = 1 + ((m_ptr - 1 + k) % (NREQ - 1));
            if (low < 0 && req_valid[i]) low = i;
        end
        if (m_force) return low;
        if (req_valid[0]) return 0;
        return low;
    endfunction

    task automatic step();
        int              g;
        bit              anylow;
        logic [NREQ-1:0] exp_ready;
        logic [AW-1:0]   a;
        @(negedge clk);
        g         = model_grant();
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        obs_ready = req_ready;
        obs_stall = stall_req;
        obs_we    = we;
        obs_waddr = waddr;
        obs_wdata = wdata;
        check("ready", 64'(obs_ready), 64'(exp_ready));
        check("stall", 64'(obs_stall), 64'(m_force && !rst));
        check("we",    64'(obs_we),    64'(m_we));
        check("waddr", 64'(obs_waddr), 64'(m_waddr));
        check("wdata", 64'(obs_wdata), 64'(m_wdata));
        m_grant = g;
        if (rst) begin
            m_ptr = 1; m_cnt = 0; m_force = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            anylow = |req_valid[NREQ-1:1];
            m_we   = 0;
            if (g >= 0) begin
                a = req_addr[g*AW +: AW];
                if (a != 0) begin
                    m_we    = 1;
                    m_waddr = a;
                    m_wdata = req_data[g*DW +: DW];
                end
            end
            if (g >= 1) begin
                m_cnt   = 0;
                m_force = 0;
                m_ptr   = (g == NREQ - 1) ? 1 : g + 1;
            end else if (anylow) begin
                m_force = (m_cnt == LIM - 1);
                if (m_cnt < LIM) m_cnt++;
            end else begin
                m_force = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // reset with every requester asking
        set_req(0, 1, 5'd3, 32'h11); set_req(1, 1, 5'd4, 32'h22); set_req(2, 1, 5'd6, 32'h33);
        step();
        step();
        check("rst_ready", 64'(obs_ready), 64'h0);
        rst = 1'b0;
        req_valid = 3'b110;
        step();
        check("rr_start", 64'(obs_ready), 64'b010);

        // single writeback write
        do_reset();
        req_valid = '0;
        set_req(0, 1, 5'd5, 32'hDEADBEEF);
        step();
        check("wb_ready", 64'(obs_ready), 64'b001);
        req_valid = '0;
        step();
        check("wb_we", 64'(obs_we), 64'h1);
        check("wb_waddr", 64'(obs_waddr), 64'd5);
        check("wb_wdata", 64'(obs_wdata), 64'hDEADBEEF);

        // two low requesters alternate
        do_reset();
        set_req(1, 1, 5'd7, 32'hAAAA0001); set_req(2, 1, 5'd9, 32'hBBBB0002);
        for (int n = 0; n < 4; n++) begin
            step();
            check("rr_alt", 64'(obs_ready), (n % 2 == 0) ? 64'b010 : 64'b100);
        end
        req_valid = '0;
        step();
        check("rr_last_addr", 64'(obs_waddr), 64'd9);

        // starvation guard
        do_reset();
        set_req(0, 1, 5'd1, 32'h0000_00A0); set_req(1, 1, 5'd2, 32'h0000_00B1);
        for (int n = 0; n < 4; n++) begin
            step();
            check("starve_wait", 64'(obs_ready), 64'b001);
        end
        step();
        check("force_ready", 64'(obs_ready), 64'b010);
        check("force_stall", 64'(obs_stall), 64'h1);
        req_valid[1] = 1'b0;
        step();
        check("force_we", 64'(obs_we), 64'h1);
        check("force_wdata", 64'(obs_wdata), 64'h0000_00B1);
        check("force_after", 64'(obs_ready), 64'b001);

        // address 0 is accepted but dropped
        do_reset();
        set_req(2, 1, 5'd0, 32'h1234);
        step();
        check("a0_ready", 64'(obs_ready), 64'b100);
        req_valid = '0;
        step();
        check("a0_we", 64'(obs_we), 64'h0);

        // reset while force is pending
        do_reset();
        set_req(0, 1, 5'd1, 32'h5); set_req(1, 1, 5'd2, 32'h6);
        for (int n = 0; n < 4; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rstf_we", 64'(obs_we), 64'h0);
        check("rstf_stall", 64'(obs_stall), 64'h0);
        check("rstf_ready", 64'(obs_ready), 64'b001);

        // randomized traffic honouring the hold-until-accepted handshake
        for (int n = 0; n < 800; n++) begin
            bit was_rst;
            rst     = ($urandom_range(0, 99) == 0);
            was_rst = rst;
            step();
            if (was_rst) req_valid = '0;
            else if (m_grant >= 0) req_valid[m_grant] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    set_req(i, 1, AW'($urandom_range(0, 31)), $urandom);
                end
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
